msm_shamir: RTL and testbench
=============================

// Module: msm_shamir
// PURPOSE
//  Parametrised multi-scalar multiplication engine: R = sum_j x[j]*G[j] over the short-Weierstrass curve y^2 = x^3 + 7 mod CURVE_P.
//  Interleaved (Shamir) double-and-add: one shared accumulator, one pass over scalar bits MSB->LSB.
//  Successor to msm_naive: start/busy/Done handshake, explicit point-at-infinity flag, equal/opposite-point handling.
//  Instantiates one point_add and one point_double unit (start/done handshake, affine curve_point_t in/out).
// PARAMETERS
//  LENGTH        2    number of (point, scalar) pairs, >=1
//  SCALAR_WIDTH  256  scalar bits processed; only x[j][SCALAR_WIDTH-1:0] is used
//  CURVE_P       37   field modulus, passed to point_add / point_double
// PORTS
//  clk     in   1                  clock
//  Reset   in   1                  synchronous, active-high reset
//  start   in   1                  request; accepted only in IDLE or DONE
//  G       in   curve_point_t [LENGTH]    affine input points; no input is the point at infinity
//  x       in   [255:0] [LENGTH]   scalars
//  busy    out  1                  high from the cycle after start is accepted until Done rises
//  Done    out  1                  level; high in DONE until the next accepted start or Reset
//  R       out  curve_point_t      result; valid while Done=1; forced to {0,0} when R_inf=1
//  R_inf   out  1                  result is the point at infinity; valid while Done=1
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, Done=0, R=0, R_inf=0; any pending sub-unit result is discarded.
//  Reset mid-operation aborts the computation; no partial result is exposed.
//  start accepted in IDLE/DONE: G and x latched; acc_inf=1; bit index i=SCALAR_WIDTH-1; j=0; Done->0; busy->1.
//  start while busy: ignored; latched operands are unaffected.
//  States and transitions:
//   IDLE     -> LOAD on start.
//   LOAD     -> DBL.
//   DBL      acc_inf: skip to SEL. acc.y==0: acc_inf=1 -> SEL. Otherwise pulse point_double -> DBL_W.
//   DBL_W    on done: acc=result -> SEL.
//   SEL      if x[j][i]==0: -> NEXT.
//            acc_inf: acc=G[j], acc_inf=0 (no adder) -> NEXT.
//            acc==G[j]: use point_double (same y==0 rule) -> ADD_W.
//            acc.x==G[j].x, y differs: acc_inf=1 -> NEXT.
//            else pulse point_add(acc, G[j]) -> ADD_W.
//   ADD_W    on done: acc=result -> NEXT.
//   NEXT     j<LENGTH-1: j++ -> SEL.
//            else if i>0: i--, j=0 -> DBL.
//            else -> DONE.
//   DONE     R=acc (or 0), R_inf=acc_inf, Done=1, busy=0; -> LOAD on start.
//  The doubling of the first (MSB) bit is a no-op because acc_inf=1 at that point.
//  Latency is data-dependent and sub-unit-latency dependent; there is no fixed cycle count.
//  Exactly one sub-unit is active at a time; each start pulse is one cycle wide.
//  All-zero scalars: R_inf=1, R={0,0}.
//  Arithmetic: coordinates are compared as full 256-bit values; inputs are assumed already reduced mod CURVE_P.
// CONFIGURATION
//  MSM_CYCLE_COUNT_EN defined: adds output port cycles [31:0].
//   cycles is cleared on accepted start and increments every cycle while busy, saturating at 32'hFFFF_FFFF.
//   cycles holds its value in DONE; reset value is 0.
//  MSM_CYCLE_COUNT_EN undefined: the cycles port and the counter are absent; all other behaviour is identical.
// TESTING (curve y^2=x^3+7 mod 37, SCALAR_WIDTH=8 unless noted)
//  1. G={(6,1),(17,6)}, x={18,80}, pulse start -> Done=1, R=(16,25), R_inf=0.
//  2. G={(6,1),(17,6)}, x={0,0} -> Done=1, R_inf=1, R=(0,0).
//  3. G={(6,1),(6,1)}, x={1,1} -> equal-point path taken; R=(18,17), R_inf=0.
//  4. G={(6,1),(6,36)}, x={1,1} -> opposite points; R_inf=1.
//  5. Run test 1 and pulse start again at mid-computation with x={1,0} -> ignored; result is still (16,25).
//     Then a new start with x={1,0} -> R=(6,1).
//  6. Assert Reset for 1 cycle mid-computation -> next cycle busy=0, Done=0, R=0.
//     A following start with test-1 operands yields (16,25).
//     With MSM_CYCLE_COUNT_EN defined: cycles>0 and stable while Done=1.

Source files
------------

// File: rtl/msm_shamir_if.sv
// Shared point type and the start/busy/Done bus of the multi-scalar multiplier.
// The bench drives the master side, msm_shamir sits on the slave side.
package msm_shamir_pkg;
   typedef struct packed {
      logic [255:0] x;
      logic [255:0] y;
   } curve_point_t;
endpackage

interface msm_shamir_if #(
   parameter int LENGTH = 2
);
   import msm_shamir_pkg::*;

   logic         start;
   curve_point_t G [LENGTH];
   logic [255:0] x [LENGTH];
   logic         busy;
   logic         Done;
   curve_point_t R;
   logic         R_inf;

   modport master (
      output start, G, x,
      input  busy, Done, R, R_inf
   );

   modport slave (
      input  start, G, x,
      output busy, Done, R, R_inf
   );
endinterface

// File: rtl/msm_shamir.sv
// Interleaved (Shamir) double-and-add MSM over y^2 = x^3 + 7 mod CURVE_P.
// Optional MSM_CYCLE_COUNT_EN adds a saturating busy-cycle counter port.

module point_add
   import msm_shamir_pkg::*;
#(
   parameter logic [255:0] CURVE_P = 256'd37,
   parameter bit           DOUBLE  = 1'b0
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic         i_start,
   input  curve_point_t i_a,
   input  curve_point_t i_b,
   output logic         o_done,
   output curve_point_t o_r
);
   typedef enum logic [1:0] {U_IDLE, U_INV, U_OUT} ustate_t;

   ustate_t      r_state;
   ustate_t      w_next;
   curve_point_t r_a;
   logic [255:0] r_bx;
   logic [255:0] r_num;
   logic [255:0] r_res;
   logic [255:0] r_base;
   logic [255:0] r_e;
   logic         r_done;
   curve_point_t r_r;
   logic [255:0] w_lam;
   logic [255:0] w_x3;
   logic [255:0] w_y3;

   function automatic logic [255:0] fmul(input logic [255:0] a,
                                         input logic [255:0] b);
      logic [511:0] t;
      t = ({256'b0, a} * {256'b0, b}) % {256'b0, CURVE_P};
      return t[255:0];
   endfunction

   function automatic logic [255:0] fsub(input logic [255:0] a,
                                         input logic [255:0] b);
      logic [256:0] t;
      t = {1'b0, a} + {1'b0, CURVE_P} - {1'b0, b};
      if (t >= {1'b0, CURVE_P})
         t = t - {1'b0, CURVE_P};
      return t[255:0];
   endfunction

   // state register
   always_ff @(posedge clk) begin
      if (Reset)
         r_state <= U_IDLE;
      else
         r_state <= w_next;
   end

   // latch operands, invert the slope denominator, then emit
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         U_IDLE:  if (i_start) w_next = U_INV;
         U_INV:   if (r_e == '0) w_next = U_OUT;
         U_OUT:   w_next = U_IDLE;
         default: w_next = U_IDLE;
      endcase
   end

   // result coordinates from slope = num * den^-1
   always_comb begin
      w_lam = fmul(r_num, r_res);
      w_x3  = fsub(fsub(fmul(w_lam, w_lam), r_a.x), r_bx);
      w_y3  = fsub(fmul(w_lam, fsub(r_a.x, w_x3)), r_a.y);
   end

   // Fermat inversion: den^(P-2), right-to-left square-and-multiply
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_done <= 1'b0;
         r_r    <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            U_IDLE: begin
               if (i_start) begin
                  r_a    <= i_a;
                  r_bx   <= DOUBLE ? i_a.x : i_b.x;
                  r_num  <= DOUBLE ? fmul(fmul(i_a.x, i_a.x), 256'd3)
                                   : fsub(i_b.y, i_a.y);
                  r_base <= DOUBLE ? fmul(i_a.y, 256'd2)
                                   : fsub(i_b.x, i_a.x);
                  r_res  <= 256'd1;
                  r_e    <= CURVE_P - 256'd2;
               end
            end
            U_INV: begin
               if (r_e != '0) begin
                  if (r_e[0])
                     r_res <= fmul(r_res, r_base);
                  r_base <= fmul(r_base, r_base);
                  r_e    <= r_e >> 1;
               end
            end
            U_OUT: begin
               r_r    <= '{x: w_x3, y: w_y3};
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_done = r_done;
   assign o_r    = r_r;
endmodule

module point_double
   import msm_shamir_pkg::*;
#(
   parameter logic [255:0] CURVE_P = 256'd37
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic         i_start,
   input  curve_point_t i_a,
   output logic         o_done,
   output curve_point_t o_r
);
   point_add #(.CURVE_P(CURVE_P), .DOUBLE(1'b1)) u_core (
      .clk     (clk),
      .Reset   (Reset),
      .i_start (i_start),
      .i_a     (i_a),
      .i_b     (i_a),
      .o_done  (o_done),
      .o_r     (o_r)
   );
endmodule

module msm_shamir
   import msm_shamir_pkg::*;
#(
   parameter int           LENGTH       = 2,
   parameter int           SCALAR_WIDTH = 256,
   parameter logic [255:0] CURVE_P      = 256'd37
) (
   input  logic        clk,
   input  logic        Reset,
`ifdef MSM_CYCLE_COUNT_EN
   output logic [31:0] cycles,
`endif
   msm_shamir_if.slave bus
);
   localparam int IW = (SCALAR_WIDTH > 1) ? $clog2(SCALAR_WIDTH) : 1;
   localparam int JW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_DBL, S_DBL_W, S_SEL, S_ADD_W, S_NEXT, S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   curve_point_t            r_G [LENGTH];
   logic [SCALAR_WIDTH-1:0] r_x [LENGTH];
   curve_point_t            r_acc;
   logic                    r_acc_inf;
   logic [IW-1:0]           r_i;
   logic [JW-1:0]           r_j;
   curve_point_t            r_R;
   logic                    r_R_inf;

   logic         w_accept;
   logic         w_busy;
   logic         w_bit;
   curve_point_t w_gj;
   logic         w_eq_x;
   logic         w_eq;
   logic         w_last_j;
   logic         w_add_start;
   logic         w_dbl_start;
   logic         w_add_done;
   logic         w_dbl_done;
   curve_point_t w_add_res;
   curve_point_t w_dbl_res;

   assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_busy   = !(r_state == S_IDLE || r_state == S_DONE);
   assign w_bit    = r_x[r_j][r_i];
   assign w_gj     = r_G[r_j];
   assign w_eq_x   = (r_acc.x == w_gj.x);
   assign w_eq     = w_eq_x && (r_acc.y == w_gj.y);
   assign w_last_j = (r_j == JW'(LENGTH - 1));

   // state register
   always_ff @(posedge clk) begin
      if (Reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // next state and sub-unit start pulses
   always_comb begin
      w_next      = r_state;
      w_add_start = 1'b0;
      w_dbl_start = 1'b0;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = S_LOAD;
         S_LOAD:  w_next = S_DBL;
         S_DBL: begin
            if (r_acc_inf || r_acc.y == '0) begin
               w_next = S_SEL;
            end else begin
               w_dbl_start = 1'b1;
               w_next      = S_DBL_W;
            end
         end
         S_DBL_W: if (w_dbl_done) w_next = S_SEL;
         S_SEL: begin
            w_next = S_NEXT;
            if (w_bit && !r_acc_inf) begin
               if (w_eq && r_acc.y != '0) begin
                  w_dbl_start = 1'b1;
                  w_next      = S_ADD_W;
               end else if (!w_eq_x) begin
                  w_add_start = 1'b1;
                  w_next      = S_ADD_W;
               end
            end
         end
         S_ADD_W: if (w_add_done || w_dbl_done) w_next = S_NEXT;
         S_NEXT: begin
            if (!w_last_j)
               w_next = S_SEL;
            else if (r_i != '0)
               w_next = S_DBL;
            else
               w_next = S_DONE;
         end
         S_DONE:  if (w_accept) w_next = S_LOAD;
         default: w_next = S_IDLE;
      endcase
   end

   // operand capture on an accepted start only
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int j = 0; j < LENGTH; j++) begin
            r_G[j] <= bus.G[j];
            r_x[j] <= bus.x[j][SCALAR_WIDTH-1:0];
         end
      end
   end

   // accumulator, bit/point indices and published result
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_acc     <= '0;
         r_acc_inf <= 1'b1;
         r_i       <= '0;
         r_j       <= '0;
         r_R       <= '0;
         r_R_inf   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_acc_inf <= 1'b1;
                  r_i       <= IW'(SCALAR_WIDTH - 1);
                  r_j       <= '0;
               end
            end
            S_DBL: begin
               if (!r_acc_inf && r_acc.y == '0)
                  r_acc_inf <= 1'b1;
            end
            S_DBL_W: begin
               if (w_dbl_done)
                  r_acc <= w_dbl_res;
            end
            S_SEL: begin
               if (w_bit) begin
                  if (r_acc_inf) begin
                     r_acc     <= w_gj;
                     r_acc_inf <= 1'b0;
                  end else if (w_eq_x && (!w_eq || r_acc.y == '0)) begin
                     r_acc_inf <= 1'b1;
                  end
               end
            end
            S_ADD_W: begin
               if (w_add_done)
                  r_acc <= w_add_res;
               else if (w_dbl_done)
                  r_acc <= w_dbl_res;
            end
            S_NEXT: begin
               if (!w_last_j) begin
                  r_j <= r_j + JW'(1);
               end else if (r_i != '0) begin
                  r_i <= r_i - IW'(1);
                  r_j <= '0;
               end else begin
                  r_R     <= r_acc_inf ? '0 : r_acc;
                  r_R_inf <= r_acc_inf;
               end
            end
            default: ;
         endcase
      end
   end

   point_add #(.CURVE_P(CURVE_P)) u_point_add (
      .clk     (clk),
      .Reset   (Reset),
      .i_start (w_add_start),
      .i_a     (r_acc),
      .i_b     (w_gj),
      .o_done  (w_add_done),
      .o_r     (w_add_res)
   );

   point_double #(.CURVE_P(CURVE_P)) u_point_double (
      .clk     (clk),
      .Reset   (Reset),
      .i_start (w_dbl_start),
      .i_a     (r_acc),
      .o_done  (w_dbl_done),
      .o_r     (w_dbl_res)
   );

`ifdef MSM_CYCLE_COUNT_EN
   logic [31:0] r_cycles;

   // busy-cycle counter, cleared on start, saturating
   always_ff @(posedge clk) begin
      if (Reset)
         r_cycles <= '0;
      else if (w_accept)
         r_cycles <= '0;
      else if (w_busy && r_cycles != 32'hFFFF_FFFF)
         r_cycles <= r_cycles + 32'd1;
   end

   assign cycles = r_cycles;
`endif

   assign bus.busy  = w_busy;
   assign bus.Done  = (r_state == S_DONE);
   assign bus.R     = r_R;
   assign bus.R_inf = r_R_inf;
endmodule

// File: tb/tb_msm_shamir.sv
// Bench for msm_shamir on y^2 = x^3 + 7 mod 37, 8-bit scalars, two points.
// Reference sums naive repeated affine additions per point.
module tb_msm_shamir;
   import msm_shamir_pkg::*;

   localparam int NL = 2;
   localparam int SW = 8;
   localparam int P  = 37;

   typedef struct {
      int x;
      int y;
      bit inf;
   } mpt_t;

   logic clk   = 1'b0;
   logic Reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   int           px [NL];
   int           py [NL];
   logic [255:0] sx [NL];
   int           qx [$];
   int           qy [$];

   msm_shamir_if #(.LENGTH(NL)) bus ();

`ifdef MSM_CYCLE_COUNT_EN
   logic [31:0] cycles;
`endif

   msm_shamir #(
      .LENGTH       (NL),
      .SCALAR_WIDTH (SW),
      .CURVE_P      (256'd37)
   ) dut (
      .clk    (clk),
      .Reset  (Reset),
`ifdef MSM_CYCLE_COUNT_EN
      .cycles (cycles),
`endif
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic int minv(input int a);
      for (int k = 1; k < P; k++)
         if ((a * k) % P == 1) return k;
      return 0;
   endfunction

   function automatic mpt_t madd(input mpt_t a, input mpt_t b);
      mpt_t r;
      int   lam;
      if (a.inf) return b;
      if (b.inf) return a;
      r.inf = 1'b0;
      if (a.x == b.x) begin
         if ((a.y + b.y) % P == 0) begin
            r.x = 0; r.y = 0; r.inf = 1'b1;
            return r;
         end
         lam = (3 * a.x * a.x) % P * minv((2 * a.y) % P) % P;
      end else begin
         lam = ((b.y - a.y + P) % P) * minv((b.x - a.x + P) % P) % P;
      end
      r.x = ((lam * lam - a.x - b.x) % P + P) % P;
      r.y = ((lam * (a.x - r.x) - a.y) % P + P) % P;
      return r;
   endfunction

   function automatic mpt_t msm_ref();
      mpt_t acc;
      mpt_t g;
      acc.x = 0; acc.y = 0; acc.inf = 1'b1;
      for (int j = 0; j < NL; j++) begin
         g.x = px[j]; g.y = py[j]; g.inf = 1'b0;
         for (int k = 0; k < int'(sx[j][SW-1:0]); k++)
            acc = madd(acc, g);
      end
      return acc;
   endfunction

   task automatic start_op();
      @(negedge clk);
      for (int j = 0; j < NL; j++) begin
         bus.G[j].x = 256'(px[j]);
         bus.G[j].y = 256'(py[j]);
         bus.x[j]   = sx[j];
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      int n;
      n = 0;
      while (bus.Done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      ok = (bus.Done === 1'b1);
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      for (int j = 0; j < NL; j++) begin
         bus.G[j] = '0;
         bus.x[j] = '0;
      end
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy got %b want 0", bus.busy);
      end
      n_cmp++;
      if (bus.Done !== 1'b0) begin
         n_err++; $display("FAIL reset_done got %b want 0", bus.Done);
      end
      n_cmp++;
      if (bus.R !== curve_point_t'(0)) begin
         n_err++; $display("FAIL reset_R got (%0d,%0d) want (0,0)", bus.R.x, bus.R.y);
      end
      n_cmp++;
      if (bus.R_inf !== 1'b0) begin
         n_err++; $display("FAIL reset_Rinf got %b want 0", bus.R_inf);
      end
   endtask

   task automatic test_vectors();
      int           tv [4][9];
      bit           ok;
      curve_point_t er;
      tv = '{'{6, 1, 17,  6, 18, 80, 16, 25, 0},
             '{6, 1, 17,  6,  0,  0,  0,  0, 1},
             '{6, 1,  6,  1,  1,  1, 18, 17, 0},
             '{6, 1,  6, 36,  1,  1,  0,  0, 1}};
      for (int v = 0; v < 4; v++) begin
         px[0] = tv[v][0]; py[0] = tv[v][1];
         px[1] = tv[v][2]; py[1] = tv[v][3];
         sx[0] = 256'(tv[v][4]);
         sx[1] = 256'(tv[v][5]);
         er.x  = 256'(tv[v][6]);
         er.y  = 256'(tv[v][7]);
         start_op();
         n_cmp++;
         if (bus.busy !== 1'b1) begin
            n_err++; $display("FAIL vec%0d_busy got %b want 1", v, bus.busy);
         end
         wait_done(ok);
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL vec%0d_done got Done=0 want 1", v);
         end
         n_cmp++;
         if (bus.R_inf !== tv[v][8][0]) begin
            n_err++; $display("FAIL vec%0d_Rinf got %b want %0d", v, bus.R_inf, tv[v][8]);
         end
         n_cmp++;
         if (bus.R !== er) begin
            n_err++; $display("FAIL vec%0d_R got (%0d,%0d) want (%0d,%0d)",
                              v, bus.R.x, bus.R.y, er.x, er.y);
         end
         repeat (3) @(negedge clk);
         n_cmp++;
         if (bus.Done !== 1'b1 || bus.busy !== 1'b0 || bus.R !== er) begin
            n_err++; $display("FAIL vec%0d_hold got Done=%b busy=%b R=(%0d,%0d) want 1,0,(%0d,%0d)",
                              v, bus.Done, bus.busy, bus.R.x, bus.R.y, er.x, er.y);
         end
      end
   endtask

   task automatic test_ignore_start();
      bit ok;
      px[0] = 6; py[0] = 1; px[1] = 17; py[1] = 6;
      sx[0] = 256'd18; sx[1] = 256'd80;
      start_op();
      repeat (3) @(negedge clk);
      sx[0] = 256'd1; sx[1] = 256'd0;
      bus.x[0] = sx[0]; bus.x[1] = sx[1];
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(ok);
      n_cmp++;
      if (!ok || bus.R_inf !== 1'b0 || bus.R.x !== 256'd16 || bus.R.y !== 256'd25) begin
         n_err++; $display("FAIL ignore_busy_start got ok=%b inf=%b (%0d,%0d) want (16,25)",
                           ok, bus.R_inf, bus.R.x, bus.R.y);
      end
      start_op();
      wait_done(ok);
      n_cmp++;
      if (!ok || bus.R_inf !== 1'b0 || bus.R.x !== 256'd6 || bus.R.y !== 256'd1) begin
         n_err++; $display("FAIL restart_from_done got ok=%b inf=%b (%0d,%0d) want (6,1)",
                           ok, bus.R_inf, bus.R.x, bus.R.y);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
`ifdef MSM_CYCLE_COUNT_EN
      logic [31:0] c0;
`endif
      px[0] = 6; py[0] = 1; px[1] = 17; py[1] = 6;
      sx[0] = 256'd18; sx[1] = 256'd80;
      start_op();
      repeat (8) @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.Done !== 1'b0) begin
         n_err++; $display("FAIL midreset_flags got busy=%b Done=%b want 0,0", bus.busy, bus.Done);
      end
      n_cmp++;
      if (bus.R !== curve_point_t'(0) || bus.R_inf !== 1'b0) begin
         n_err++; $display("FAIL midreset_R got (%0d,%0d) inf=%b want (0,0) 0",
                           bus.R.x, bus.R.y, bus.R_inf);
      end
      repeat (40) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.Done !== 1'b0) begin
         n_err++; $display("FAIL midreset_stays_idle got busy=%b Done=%b want 0,0", bus.busy, bus.Done);
      end
      start_op();
      wait_done(ok);
      n_cmp++;
      if (!ok || bus.R_inf !== 1'b0 || bus.R.x !== 256'd16 || bus.R.y !== 256'd25) begin
         n_err++; $display("FAIL after_reset got ok=%b inf=%b (%0d,%0d) want (16,25)",
                           ok, bus.R_inf, bus.R.x, bus.R.y);
      end
`ifdef MSM_CYCLE_COUNT_EN
      c0 = cycles;
      n_cmp++;
      if (c0 == 32'd0) begin
         n_err++; $display("FAIL cycles_nonzero got %0d want >0", c0);
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (cycles !== c0) begin
         n_err++; $display("FAIL cycles_hold got %0d want %0d", cycles, c0);
      end
`endif
   endtask

   task automatic test_random();
      bit           ok;
      mpt_t         e;
      curve_point_t er;
      int           k;
      for (int y = 0; y < P; y++)
         for (int x = 0; x < P; x++)
            if ((y * y) % P == (x * x * x + 7) % P) begin
               qx.push_back(x);
               qy.push_back(y);
            end
      for (int t = 0; t < 25; t++) begin
         for (int j = 0; j < NL; j++) begin
            k     = $urandom_range(0, qx.size() - 1);
            px[j] = qx[k];
            py[j] = qy[k];
            sx[j] = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 4) == 0)
               sx[j][SW-1:0] = '0;
         end
         if ($urandom_range(0, 4) == 0) begin
            px[1] = px[0];
            py[1] = ($urandom_range(0, 1) == 0) ? py[0] : (P - py[0]) % P;
         end
         e    = msm_ref();
         er.x = e.inf ? 256'd0 : 256'(e.x);
         er.y = e.inf ? 256'd0 : 256'(e.y);
         start_op();
         wait_done(ok);
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL rnd%0d_done got Done=0 want 1", t);
         end
         n_cmp++;
         if (bus.R_inf !== e.inf) begin
            n_err++; $display("FAIL rnd%0d_Rinf got %b want %b", t, bus.R_inf, e.inf);
         end
         n_cmp++;
         if (bus.R !== er) begin
            n_err++; $display("FAIL rnd%0d_R got (%0d,%0d) want (%0d,%0d)",
                              t, bus.R.x, bus.R.y, er.x, er.y);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_start();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
